// File: rtl/enemy_pkg.sv
// Shared definitions for enemy blocks: state encoding and default geometry.
package enemy_pkg;

   localparam int unsigned COORD_W    = 10;
   localparam int unsigned SPRITE_DEF = 12;

   typedef enum logic [1:0] {
      ST_WALK  = 2'd0,
      ST_SHELL = 2'd1,
      ST_GONE  = 2'd2
   } enemy_state_t;

endpackage

// File: rtl/enemy_patrol_if.sv
// Character/scroll inputs and render/status outputs of one enemy instance.
interface enemy_patrol_if #(
   parameter int unsigned W = 10
);
   logic         frame_tick;
   logic [W-1:0] char_X;
   logic [W-1:0] char_Y;
   logic [W-1:0] bg_pos;
   logic [W-1:0] enemy_x;
   logic [W-1:0] enemy_y;
   logic         death;
   logic         stomp;
   logic         en;
   logic [1:0]   state;

   modport master (
      output frame_tick, char_X, char_Y, bg_pos,
      input  enemy_x, enemy_y, death, stomp, en, state
   );

   modport slave (
      input  frame_tick, char_X, char_Y, bg_pos,
      output enemy_x, enemy_y, death, stomp, en, state
   );
endinterface

// File: rtl/enemy_patrol_tick_divider.sv
// frame_tick prescaler: o_term_c fires on the DIV-th tick; i_clr holds the count at zero.
module tick_divider #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_tick,
   output logic o_term_c
);
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last   = (r_cnt == CW'(DIV - 1));
   assign o_term_c = i_tick && !i_clr && w_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_cnt <= '0;
      else if (i_clr)   r_cnt <= '0;
      else if (i_tick)  r_cnt <= w_last ? '0 : r_cnt + CW'(1);
   end
endmodule

// File: rtl/enemy_patrol.sv
// One patrolling enemy: walks between X_MIN/X_MAX, shells on stomp, recovers after a timeout,
// removed on a second stomp; side contact while walking kills the character.
module enemy_patrol
   import enemy_pkg::*;
#(
   parameter int unsigned W            = COORD_W,
   parameter int unsigned SPRITE       = SPRITE_DEF,
   parameter int unsigned X_INIT       = 468,
   parameter int unsigned Y_INIT       = 80,
   parameter int unsigned X_MIN        = 420,
   parameter int unsigned X_MAX        = 520,
   parameter int unsigned STEP_DIV     = 4,
   parameter int unsigned SHELL_FRAMES = 180
) (
   input  logic          sys_clk,
   input  logic          RST_N,
   enemy_patrol_if.slave bus
);
   localparam int unsigned XW = W + 1;

   enemy_state_t r_state;
   logic [W-1:0] r_x;
   logic         r_dir;
   logic         r_death;
   logic         r_stomp;
   logic         r_en;
   logic         r_stomp_q;

   logic [XW-1:0] w_cx;
   logic [XW-1:0] w_cy;
   logic [XW-1:0] w_xr;
   logic          w_x_ov;
   logic          w_stomp_cond;
   logic          w_side;
   logic          w_stomp_acc;
   logic          w_step;
   logic          w_shell_done;

   // Overlap and contact tests in W+1 bits so the sprite offset never wraps.
   assign w_cx         = {1'b0, bus.char_X};
   assign w_cy         = {1'b0, bus.char_Y};
   assign w_xr         = {1'b0, r_x};
   assign w_x_ov       = ((w_cx + XW'(SPRITE)) > w_xr) && (w_cx < (w_xr + XW'(SPRITE)));
   assign w_stomp_cond = w_x_ov && ((w_cy + XW'(SPRITE)) == XW'(Y_INIT));
   assign w_side       = w_x_ov && (bus.char_Y == W'(Y_INIT));
   // A held stomp counts once: only the first cycle of the condition is accepted.
   assign w_stomp_acc  = w_stomp_cond && !r_stomp_q;

   tick_divider #(.DIV(STEP_DIV)) u_step_div (
      .clk      (sys_clk),
      .rst_n    (RST_N),
      .i_clr    ((r_state != ST_WALK) || w_stomp_acc),
      .i_tick   (bus.frame_tick),
      .o_term_c (w_step)
   );

   tick_divider #(.DIV(SHELL_FRAMES)) u_shell_tmr (
      .clk      (sys_clk),
      .rst_n    (RST_N),
      .i_clr    ((r_state != ST_SHELL) || w_stomp_acc),
      .i_tick   (bus.frame_tick),
      .o_term_c (w_shell_done)
   );

   always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= ST_WALK;
         r_x       <= W'(X_INIT);
         r_dir     <= 1'b1;
         r_death   <= 1'b0;
         r_stomp   <= 1'b0;
         r_en      <= 1'b1;
         r_stomp_q <= 1'b0;
      end else begin
         r_stomp_q <= w_stomp_cond;
         r_stomp   <= 1'b0;
         r_death   <= 1'b0;
         case (r_state)
            ST_WALK: begin
               r_death <= w_side;
               if (w_stomp_acc) begin
                  r_state <= ST_SHELL;
                  r_stomp <= 1'b1;
               end else if (w_step) begin
                  if (r_dir) begin
                     if (r_x == W'(X_MAX)) r_dir <= 1'b0;
                     else                  r_x   <= r_x + W'(1);
                  end else begin
                     if (r_x == W'(X_MIN)) r_dir <= 1'b1;
                     else                  r_x   <= r_x - W'(1);
                  end
               end
            end
            ST_SHELL: begin
               if (w_stomp_acc) begin
                  r_state <= ST_GONE;
                  r_stomp <= 1'b1;
                  r_en    <= 1'b0;
               end else if (w_shell_done) begin
                  r_state <= ST_WALK;
               end
            end
            ST_GONE: begin
               r_en <= 1'b0;
            end
            default: begin
               r_state <= ST_WALK;
            end
         endcase
      end
   end

   assign bus.enemy_x = r_x - bus.bg_pos;
   assign bus.enemy_y = W'(Y_INIT);
   assign bus.death   = r_death;
   assign bus.stomp   = r_stomp;
   assign bus.en      = r_en;
   assign bus.state   = r_state;
endmodule

// File: tb/tb_enemy_patrol.sv
// Directed bench for enemy_patrol: patrol, reversal, contact, shell timeout, removal, async reset.
module tb_enemy_patrol;
   logic sys_clk = 1'b0;
   logic RST_N   = 1'b1;
   int   n_run   = 0;
   int   n_fail  = 0;

   enemy_patrol_if #(.W(10)) bus ();

   enemy_patrol u_dut (
      .sys_clk (sys_clk),
      .RST_N   (RST_N),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         bus.frame_tick = 1'b1;
         cyc();
         bus.frame_tick = 1'b0;
         cyc();
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic away();
      bus.char_X = 10'd0;
      bus.char_Y = 10'd0;
   endtask

   initial begin
      bus.frame_tick = 1'b0;
      bus.bg_pos     = 10'd0;
      away();
      #1 RST_N = 1'b0;
      #10;
      chk("rst_state", 32'(bus.state), 0);
      chk("rst_x", 32'(bus.enemy_x), 468);
      chk("rst_y", 32'(bus.enemy_y), 80);
      chk("rst_en", 32'(bus.en), 1);
      chk("rst_death", 32'(bus.death), 0);
      chk("rst_stomp", 32'(bus.stomp), 0);
      cyc();
      RST_N = 1'b1;
      cyc();

      // 1: two steps in 8 ticks
      tick(8);
      chk("walk8_x", 32'(bus.enemy_x), 470);
      chk("walk8_en", 32'(bus.en), 1);
      chk("walk8_death", 32'(bus.death), 0);
      chk("walk8_state", 32'(bus.state), 0);

      // 2: reversal at both bounds
      tick(200);
      chk("reach_max", 32'(bus.enemy_x), 520);
      tick(4);
      chk("hold_max", 32'(bus.enemy_x), 520);
      tick(3);
      chk("pre_back", 32'(bus.enemy_x), 520);
      tick(1);
      chk("back_519", 32'(bus.enemy_x), 519);
      tick(396);
      chk("reach_min", 32'(bus.enemy_x), 420);
      tick(4);
      chk("hold_min", 32'(bus.enemy_x), 420);
      tick(4);
      chk("fwd_421", 32'(bus.enemy_x), 421);

      // 3: side contact
      bus.char_X = 10'd416;
      bus.char_Y = 10'd80;
      cyc();
      chk("side_death", 32'(bus.death), 1);
      cyc();
      chk("side_death_hold", 32'(bus.death), 1);
      bus.char_X = 10'd0;
      cyc();
      chk("side_death_drop", 32'(bus.death), 0);

      // 4: stomp into shell, held stomp ignored, harmless shell
      bus.char_X = 10'd421;
      bus.char_Y = 10'd68;
      cyc();
      chk("stomp1_pulse", 32'(bus.stomp), 1);
      chk("stomp1_state", 32'(bus.state), 1);
      cyc();
      chk("stomp1_once", 32'(bus.stomp), 0);
      chk("stomp1_held", 32'(bus.state), 1);
      bus.char_Y = 10'd80;
      cyc();
      chk("shell_side", 32'(bus.death), 0);
      chk("shell_side_st", 32'(bus.state), 1);
      away();
      cyc();

      // 5: shell timeout, resume walking
      tick(179);
      chk("shell_179", 32'(bus.state), 1);
      chk("shell_frozen", 32'(bus.enemy_x), 421);
      tick(1);
      chk("shell_180", 32'(bus.state), 0);
      tick(3);
      chk("resume_3", 32'(bus.enemy_x), 421);
      tick(1);
      chk("resume_4", 32'(bus.enemy_x), 422);

      // 5b: stomp on timeout cycle wins
      bus.char_X = 10'd422;
      bus.char_Y = 10'd68;
      cyc();
      chk("stomp2_state", 32'(bus.state), 1);
      away();
      cyc();
      tick(179);
      chk("shell2_179", 32'(bus.state), 1);
      bus.char_X = 10'd422;
      bus.char_Y = 10'd68;
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      chk("gone_state", 32'(bus.state), 2);
      chk("gone_stomp", 32'(bus.stomp), 1);
      chk("gone_en", 32'(bus.en), 0);
      away();
      cyc();
      chk("gone_stomp_once", 32'(bus.stomp), 0);
      tick(8);
      chk("gone_frozen", 32'(bus.enemy_x), 422);
      chk("gone_stays", 32'(bus.state), 2);
      bus.char_X = 10'd418;
      bus.char_Y = 10'd80;
      cyc();
      chk("gone_no_death", 32'(bus.death), 0);
      away();

      // 6: async reset from shell
      #2 RST_N = 1'b0;
      #1 RST_N = 1'b1;
      cyc();
      chk("rst2_state", 32'(bus.state), 0);
      chk("rst2_en", 32'(bus.en), 1);
      tick(4);
      chk("rst2_step", 32'(bus.enemy_x), 469);
      bus.char_X = 10'd469;
      bus.char_Y = 10'd68;
      cyc();
      chk("stomp3_state", 32'(bus.state), 1);
      away();
      cyc();
      tick(5);
      #2 RST_N = 1'b0;
      #1;
      chk("async_state", 32'(bus.state), 0);
      chk("async_x", 32'(bus.enemy_x), 468);
      chk("async_en", 32'(bus.en), 1);
      chk("async_stomp", 32'(bus.stomp), 0);
      bus.bg_pos = 10'd500;
      #1;
      chk("wrap_x", 32'(bus.enemy_x), 992);
      bus.bg_pos = 10'd0;
      #2 RST_N = 1'b1;
      cyc();
      chk("post_rst_state", 32'(bus.state), 0);
      chk("post_rst_x", 32'(bus.enemy_x), 468);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
